// File: rtl/onehot_seq_decoder.sv
// onehot_seq_decoder: registered SEL_W-to-2^SEL_W one-hot select with a
// command handshake. A command either holds one index (direct) or walks a
// wrapping index range, dwelling dwell+1 cycles on each position (scan).
module onehot_seq_decoder #(
   parameter int SEL_W   = 3,
   parameter int DWELL_W = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_mode,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic [SEL_W-1:0]        in_last,
   input  logic [DWELL_W-1:0]      in_dwell,
   input  logic                    en,
   output logic [(1<<SEL_W)-1:0]   dout,
   output logic                    busy,
   output logic                    done
);

   localparam int N = 1 << SEL_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      SCAN = 2'd2
   } state_t;

   state_t               state;
   state_t               state_next;
   logic [SEL_W-1:0]     idx;
   logic [SEL_W-1:0]     idx_next;
   logic [SEL_W-1:0]     last;
   logic [SEL_W-1:0]     last_next;
   logic [DWELL_W-1:0]   dwell;
   logic [DWELL_W-1:0]   dwell_next;
   logic [DWELL_W-1:0]   cnt;
   logic [DWELL_W-1:0]   cnt_next;
   logic                 done_next;
   logic [N-1:0]         dout_next;

   function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] i);
      logic [N-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // A command can be taken whenever no scan is running and no reset/clear is pending
   assign in_ready = ~rst & ~clr & (state != SCAN);

   // Next-state decision: clear beats command accept, which beats scan progress
   always_comb begin
      state_next = state;
      idx_next   = idx;
      last_next  = last;
      dwell_next = dwell;
      cnt_next   = cnt;
      done_next  = 1'b0;
      if (clr) begin
         state_next = IDLE;
         cnt_next   = '0;
      end else if (in_valid && (state != SCAN)) begin
         idx_next = in_sel;
         if (in_mode) begin
            state_next = SCAN;
            last_next  = in_last;
            dwell_next = in_dwell;
            cnt_next   = '0;
         end else begin
            state_next = HOLD;
         end
      end else if (state == SCAN) begin
         if (cnt != dwell) begin
            cnt_next = cnt + DWELL_W'(1);
         end else if (idx == last) begin
            state_next = IDLE;
            done_next  = 1'b1;
         end else begin
            idx_next = idx + SEL_W'(1);
            cnt_next = '0;
         end
      end
      dout_next = (en && (state_next != IDLE)) ? onehot(idx_next) : '0;
   end

   // State, scan bookkeeping and all outputs are registered together so dout never glitches
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
         last  <= '0;
         dwell <= '0;
         cnt   <= '0;
         dout  <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         idx   <= idx_next;
         last  <= last_next;
         dwell <= dwell_next;
         cnt   <= cnt_next;
         dout  <= dout_next;
         busy  <= (state_next == SCAN);
         done  <= done_next;
      end
   end

endmodule

// File: doc/onehot_seq_decoder.md
# onehot_seq_decoder

Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with a command handshake and an autonomous scan mode. It is the next generation of our gate-level 3-to-8 decoder. It sits between a control sequencer and select-line consumers (row/bank/channel enables). Select lines can be held on one index, or walked through a wrapping index range with a programmable dwell per position.

## Interface
Parameters:
- SEL_W, 3, index width; output width is N = 2^SEL_W.
- DWELL_W, 4, dwell counter width; each scan position is held dwell+1 cycles.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- clr  input  1  synchronous soft clear to IDLE; does not pulse done.
- in_valid  input  1  command valid.
- in_ready  output  1  command accepted when in_valid & in_ready at a rising edge.
- in_mode  input  1  0 = direct (hold one index), 1 = scan.
- in_sel  input  SEL_W  direct index, or scan start index.
- in_last  input  SEL_W  scan end index (inclusive); ignored in direct mode.
- in_dwell  input  DWELL_W  scan dwell; ignored in direct mode.
- en  input  1  output enable; 0 forces dout to zero.
- dout  output  N  registered one-hot select, or all-zero.
- busy  output  1  high while in SCAN.
- done  output  1  one-cycle pulse at scan completion.

## Operation
- States:
  - IDLE: no selection; dout=0.
  - HOLD: dout = onehot(idx).
  - SCAN: walking the index range.
- in_ready = ~rst & ~clr & (state != SCAN). It is high in IDLE and HOLD.
- Accepting a direct command from IDLE or HOLD:
  - idx <= in_sel; next state HOLD.
  - A new direct command in HOLD switches the index with no zero gap.
- Accepting a scan command from IDLE or HOLD:
  - idx <= in_sel, last <= in_last, dwell <= in_dwell, cnt <= 0; next state SCAN.
- In SCAN, each cycle:
  - If cnt != dwell: cnt++.
  - Else if idx == last: go to IDLE and pulse done.
  - Else: idx <= idx+1 (modulo N, so N-1 wraps to 0) and cnt <= 0.
- Scan length is L = ((last - sel) mod N) + 1 positions. in_sel == in_last gives a single position.
- dout register next value = (en && state_next in {HOLD, SCAN}) ? onehot(idx_next) : 0.
  - en is sampled; it only gates dout and never stalls the FSM or counters.
- Priority: rst > clr > command accept > scan progress.
- rst or clr mid-scan: next state IDLE, dout=0, busy=0, done=0. The in-flight scan is discarded.
- dout is always zero or exactly one-hot; no transient multi-hot values.

## Timing
- Reset values: dout=0, busy=0, done=0, in_ready=0 while rst is high, state IDLE, idx=0, cnt=0.
- Direct latency: command accepted at edge k → dout=onehot(in_sel) from edge k. It is visible in the cycle after acceptance and holds until the next command, clr or rst.
- Scan latency: accepted at edge k → busy=1 and dout=onehot(in_sel) from edge k.
  - Position j (0-based) is driven for exactly dwell+1 cycles, starting at edge k + j·(dwell+1).
- Scan end: at edge k + L·(dwell+1):
  - dout=0, busy=0, done=1 for exactly one cycle, in_ready=1.
  - A command presented in that cycle is accepted.
- en transition at edge e: dout reflects it from edge e+1. One register stage, no combinational path from en to dout.
- in_valid while busy: in_ready=0, so the command is not consumed. The source holds it.

## Test plan
- Reset and direct: rst 2 cycles, then in_valid=1, in_mode=0, in_sel=5, en=1 → dout=8'b0010_0000 one cycle after accept. Then in_sel=2 → dout=8'b0000_0100 next cycle, with no zero cycle between.
- Scan with wrap: in_mode=1, in_sel=6, in_last=1, in_dwell=1 → dout is 0x40, 0x40, 0x80, 0x80, 0x01, 0x01, 0x02, 0x02. Then dout=0 with done=1 for one cycle. busy=1 for exactly 8 cycles.
- Single position, zero dwell: in_sel=in_last=3, in_dwell=0 → dout=0x08 for one cycle, then done pulse. Back-to-back direct command in the done cycle is accepted.
- Backpressure and en: in_valid held during a scan → in_ready=0 and the command is taken only at the done cycle. en=0 for 3 mid-scan cycles → dout=0 for those cycles, offset by one. Scan end time is unchanged.
- Abort: clr (then separately rst) asserted in the 3rd cycle of a scan with dwell=2, in_sel=0, in_last=7 → next cycle dout=0, busy=0, done stays 0. in_valid asserted in the clr cycle is not accepted.
